// File: rtl/cnt_clk_div_gen_pkg.sv
// Shared types and helpers for the divided-clock / tick generator.
// Optional feature macro: CNT_CLK_DIV_GEN_GATE_EN (per-channel gate input).
package cnt_clk_div_pkg;

  // Widest channel counter the helpers below are sized for.
  localparam int CNT_W_MAX = 16;

  // Per-channel operation chosen each cycle, in priority order.
  typedef enum logic [2:0] {
    CH_RESET = 3'd0,
    CH_CLEAR = 3'd1,
    CH_RUN   = 3'd2,
    CH_GATED = 3'd3,
    CH_HOLD  = 3'd4
  } ch_op_e;

  // Width of one channel's divisor select.
  function automatic int sel_width(input int cnt_w);
    return $clog2(cnt_w);
  endfunction

  // Out-of-range selects saturate to the largest legal ratio.
  function automatic logic [15:0] clamp_sel(input logic [15:0] sel, input int cnt_w);
    logic [15:0] res;
    if (int'(sel) >= cnt_w) begin
      res = 16'(cnt_w - 1);
    end else begin
      res = sel;
    end
    return res;
  endfunction

  // Terminal count 2^(s+1)-1, built by shifting ones so the maximum
  // ratio never needs a wider intermediate than the counter itself.
  function automatic logic [15:0] term(input int s, input int cnt_w);
    int sc;
    sc = (s >= cnt_w) ? (cnt_w - 1) : s;
    return 16'hFFFF >> (15 - sc);
  endfunction

endpackage

// File: rtl/cnt_clk_div_gen_if.sv
// Control/status bundle of the divided-clock generator.
// Optional feature macro: CNT_CLK_DIV_GEN_GATE_EN adds ch_en.
interface cnt_clk_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 3
);
  logic                    en;
  logic                    sync_clr;
  logic [NUM_CH*SEL_W-1:0] div_sel;
  logic [NUM_CH-1:0]       clk_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*SEL_W-1:0] sel_act;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
  logic [NUM_CH-1:0]       ch_en;

  modport master (output en, sync_clr, div_sel, ch_en, input clk_div, tick, sel_act);
  modport slave  (input en, sync_clr, div_sel, ch_en, output clk_div, tick, sel_act);
`else
  modport master (output en, sync_clr, div_sel, input clk_div, tick, sel_act);
  modport slave  (input en, sync_clr, div_sel, output clk_div, tick, sel_act);
`endif
endinterface

// File: rtl/cnt_clk_div_gen_ch.sv
// One divided-clock channel: period counter, applied-select shadow,
// registered 50% level and one-cycle tick. Selects (and the optional
// gate, macro CNT_CLK_DIV_GEN_GATE_EN) only change at period boundaries
// so a period is never shortened.
module cnt_clk_div_ch
  import cnt_clk_div_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SEL_W = sel_width(CNT_W)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [SEL_W-1:0] div_sel,
`ifdef CNT_CLK_DIV_GEN_GATE_EN
  input  logic             ch_en,
`endif
  output logic             clk_div,
  output logic             tick,
  output logic [SEL_W-1:0] sel_act
);

  logic [CNT_W-1:0] ccnt_r;
  logic [CNT_W-1:0] term_s;
  logic [CNT_W-1:0] half_s;
  logic [CNT_W-1:0] ccnt_nxt_s;
  logic [SEL_W-1:0] sel_new_s;
  logic             at_term_s;
  logic             gate_open_s;
  ch_op_e           op_s;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
  logic             ch_en_act_r;
`endif

  // Next-count, boundary detect and the operation selected by priority.
  always_comb begin
    logic [15:0] sel16;
    logic [15:0] term16;
    sel16      = clamp_sel(16'(div_sel), CNT_W);
    sel_new_s  = sel16[SEL_W-1:0];
    term16     = term(int'(sel_act), CNT_W);
    term_s     = term16[CNT_W-1:0];
    half_s     = CNT_W'(1) << sel_act;
    at_term_s  = (ccnt_r == term_s);
    if (at_term_s) begin
      ccnt_nxt_s = '0;
    end else begin
      ccnt_nxt_s = ccnt_r + CNT_W'(1);
    end
`ifdef CNT_CLK_DIV_GEN_GATE_EN
    gate_open_s = ch_en_act_r;
`else
    gate_open_s = 1'b1;
`endif
    if (sys_rst) begin
      op_s = CH_RESET;
    end else if (sync_clr) begin
      op_s = CH_CLEAR;
    end else if (en && gate_open_s) begin
      op_s = CH_RUN;
    end else if (en) begin
      op_s = CH_GATED;
    end else begin
      op_s = CH_HOLD;
    end
  end

  // Channel state update; outputs come straight from these registers.
  always_ff @(posedge sys_clk) begin
    case (op_s)
      CH_RESET: begin
        ccnt_r  <= '0;
        sel_act <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
        ch_en_act_r <= 1'b0;
`endif
      end
      CH_CLEAR: begin
        ccnt_r  <= '0;
        sel_act <= sel_new_s;
        clk_div <= 1'b0;
        tick    <= 1'b0;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
        ch_en_act_r <= ch_en;
`endif
      end
      CH_RUN: begin
        ccnt_r  <= ccnt_nxt_s;
        clk_div <= ccnt_nxt_s[sel_act];
        tick    <= (ccnt_nxt_s == half_s);
        if (at_term_s) begin
          sel_act <= sel_new_s;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
          ch_en_act_r <= ch_en;
`endif
        end else begin
          sel_act <= sel_act;
        end
      end
      CH_GATED: begin
        // Parked at count zero: free to pick up a new select and gate.
        ccnt_r  <= '0;
        sel_act <= sel_new_s;
        clk_div <= 1'b0;
        tick    <= 1'b0;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
        ch_en_act_r <= ch_en;
`endif
      end
      CH_HOLD: begin
        tick <= 1'b0;
      end
      default: begin
        ccnt_r  <= '0;
        sel_act <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
        ch_en_act_r <= 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/cnt_clk_div_gen.sv
// Multi-channel power-of-two clock divider and tick generator for the
// timer counter core. Optional macro CNT_CLK_DIV_GEN_GATE_EN adds a
// per-channel boundary-aligned gate (ch_en on the interface).
module cnt_clk_div_gen
  import cnt_clk_div_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = sel_width(CNT_W)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  cnt_clk_div_gen_if.slave bus
);

  logic [NUM_CH-1:0]       clk_div_s;
  logic [NUM_CH-1:0]       tick_s;
  logic [NUM_CH*SEL_W-1:0] sel_act_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cnt_clk_div_ch #(
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .en       (bus.en),
      .sync_clr (bus.sync_clr),
      .div_sel  (bus.div_sel[k*SEL_W +: SEL_W]),
`ifdef CNT_CLK_DIV_GEN_GATE_EN
      .ch_en    (bus.ch_en[k]),
`endif
      .clk_div  (clk_div_s[k]),
      .tick     (tick_s[k]),
      .sel_act  (sel_act_s[k*SEL_W +: SEL_W])
    );
  end

  assign bus.clk_div = clk_div_s;
  assign bus.tick    = tick_s;
  assign bus.sel_act = sel_act_s;

endmodule

// File: tb/tb_cnt_clk_div_gen.sv
// Randomised self-checking bench for cnt_clk_div_gen with a period-level
// reference model, plus directed scenarios pinned by literal values.
module tb_cnt_clk_div_gen;
  import cnt_clk_div_pkg::*;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
  localparam bit GATE_RST = 1'b0;
`else
  localparam bit GATE_RST = 1'b1;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic chk_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [NUM_CH-1:0] ch_en_tb;

  always #5 sys_clk = ~sys_clk;

  cnt_clk_div_gen_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();
  cnt_clk_div_gen_if #(.NUM_CH(2), .SEL_W(3)) bus6 ();

  cnt_clk_div_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  cnt_clk_div_gen #(.CNT_W(6), .NUM_CH(2)) dut6 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus6)
  );

`ifdef CNT_CLK_DIV_GEN_GATE_EN
  assign bus.ch_en  = ch_en_tb;
  assign bus6.ch_en = 2'b11;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_m(input int s, input int cw);
    return (s >= cw) ? (cw - 1) : s;
  endfunction

  // Reference model: position within the current period and applied ratio.
  int                      m_pos  [NUM_CH];
  int                      m_sel  [NUM_CH];
  bit                      m_gate [NUM_CH];
  int                      m_req;
  int                      m_per;
  logic [NUM_CH-1:0]       exp_div;
  logic [NUM_CH-1:0]       exp_tick;
  logic [NUM_CH*SEL_W-1:0] exp_sel;

  always @(posedge sys_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      m_req = clamp_m(int'(bus.div_sel[k*SEL_W +: SEL_W]), CNT_W);
      if (sys_rst) begin
        m_pos[k] = 0; m_sel[k] = 0; m_gate[k] = GATE_RST;
        exp_div[k] = 1'b0; exp_tick[k] = 1'b0;
      end else if (bus.sync_clr) begin
        m_pos[k] = 0; m_sel[k] = m_req; m_gate[k] = ch_en_tb[k];
        exp_div[k] = 1'b0; exp_tick[k] = 1'b0;
      end else if (bus.en && m_gate[k]) begin
        m_per = 2 << m_sel[k];
        m_pos[k] = (m_pos[k] + 1) % m_per;
        exp_div[k]  = (m_pos[k] >= m_per / 2);
        exp_tick[k] = (m_pos[k] == m_per / 2);
        if (m_pos[k] == 0) begin
          m_sel[k] = m_req;
          m_gate[k] = ch_en_tb[k];
        end
      end else if (bus.en) begin
        m_pos[k] = 0; m_sel[k] = m_req; m_gate[k] = ch_en_tb[k];
        exp_div[k] = 1'b0; exp_tick[k] = 1'b0;
      end else begin
        exp_tick[k] = 1'b0;
      end
      exp_sel[k*SEL_W +: SEL_W] = SEL_W'(m_sel[k]);
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("clk_div", 32'(bus.clk_div), 32'(exp_div));
      chk("tick",    32'(bus.tick),    32'(exp_tick));
      chk("sel_act", 32'(bus.sel_act), 32'(exp_sel));
    end
  end

  int tick_cnt [NUM_CH];
  int hi_cnt   [NUM_CH];
  int tick6    [2];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic run_count(input int n);
    for (int k = 0; k < NUM_CH; k++) begin
      tick_cnt[k] = 0; hi_cnt[k] = 0;
    end
    tick6[0] = 0; tick6[1] = 0;
    repeat (n) begin
      @(posedge sys_clk);
      #2;
      for (int k = 0; k < NUM_CH; k++) begin
        tick_cnt[k] += int'(bus.tick[k]);
        hi_cnt[k]   += int'(bus.clk_div[k]);
      end
      tick6[0] += int'(bus6.tick[0]);
      tick6[1] += int'(bus6.tick[1]);
    end
  endtask

  task automatic clr_pulse();
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
  endtask

  initial begin
    int first_n;
    bit found;
    logic [2:0] s3;

    sys_rst = 1'b1;
    bus.en = 1'b1; bus.sync_clr = 1'b0; bus.div_sel = '0;
    bus6.en = 1'b1; bus6.sync_clr = 1'b0; bus6.div_sel = '0;
    ch_en_tb = '1;

    // Reset / div2.
    @(posedge sys_clk); #2;
    chk_on = 1'b1;
    step(2);
    chk("rst_clk_div", 32'(bus.clk_div), 32'h0);
    chk("rst_tick",    32'(bus.tick),    32'h0);
    chk("rst_sel_act", 32'(bus.sel_act), 32'h0);
    sys_rst = 1'b0;
`ifdef CNT_CLK_DIV_GEN_GATE_EN
    step(1);
`endif
    step(1);
    chk("div2_tick_e1", 32'(bus.tick),    32'hF);
    chk("div2_div_e1",  32'(bus.clk_div), 32'hF);
    step(1);
    chk("div2_tick_e2", 32'(bus.tick),    32'h0);
    step(1);
    chk("div2_tick_e3", 32'(bus.tick),    32'hF);

    // Ratios 16/8/4/2 on channels 0..3.
    bus.div_sel = {3'd0, 3'd1, 3'd2, 3'd3};
    clr_pulse();
    run_count(256);
    chk("ratio_ticks_ch0", 32'(tick_cnt[0]), 32'd16);
    chk("ratio_ticks_ch1", 32'(tick_cnt[1]), 32'd32);
    chk("ratio_ticks_ch2", 32'(tick_cnt[2]), 32'd64);
    chk("ratio_ticks_ch3", 32'(tick_cnt[3]), 32'd128);
    chk("ratio_hi_ch0",    32'(hi_cnt[0]),   32'd128);
    chk("ratio_hi_ch3",    32'(hi_cnt[3]),   32'd128);

    // Boundary switch: ch0 sel 2 -> 0 requested at count 5.
    bus.div_sel[2:0] = 3'd2;
    clr_pulse();
    step(5);
    bus.div_sel[2:0] = 3'd0;
    step(2);
    chk("bswitch_sel_hold", 32'(bus.sel_act[2:0]), 32'd2);
    run_count(11);
    chk("bswitch_ticks",    32'(tick_cnt[0]),      32'd5);
    chk("bswitch_sel_new",  32'(bus.sel_act[2:0]), 32'd0);

    // Enable low mid-period, then restart with sel=3.
    bus.div_sel = {4{3'd3}};
    step(3);
    bus.en = 1'b0;
    step(10);
    bus.en = 1'b1;
    step(4);
    clr_pulse();
    chk("clr_clk_div", 32'(bus.clk_div), 32'h0);
    found = 1'b0; first_n = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      step(1);
      if (bus.tick[0]) begin
        found = 1'b1; first_n = i;
      end
    end
    chk("clr_first_tick", 32'(first_n), 32'd8);

    // Maximum ratio.
    bus.div_sel = {4{3'd7}};
    clr_pulse();
    run_count(512);
    chk("max_ticks_ch0", 32'(tick_cnt[0]), 32'd2);
    chk("max_hi_ch3",    32'(hi_cnt[3]),   32'd256);

    // Clamp on the CNT_W=6 instance.
    bus6.div_sel = {3'd6, 3'd7};
    bus6.sync_clr = 1'b1;
    step(1);
    bus6.sync_clr = 1'b0;
    chk("clamp_sel_act", 32'(bus6.sel_act), 32'o55);
    run_count(128);
    chk("clamp_ticks_ch0", 32'(tick6[0]), 32'd2);
    chk("clamp_ticks_ch1", 32'(tick6[1]), 32'd2);

`ifdef CNT_CLK_DIV_GEN_GATE_EN
    // Gate drop mid-period on ch1 at sel=1, then re-enable.
    bus.div_sel[5:3] = 3'd1;
    clr_pulse();
    step(2);
    ch_en_tb[1] = 1'b0;
    step(10);
    chk("gate_off_div", 32'(bus.clk_div[1]), 32'd0);
    ch_en_tb[1] = 1'b1;
    step(10);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en       = ($urandom_range(0, 7) != 0);
      bus.sync_clr = ($urandom_range(0, 96) == 0);
      sys_rst      = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < NUM_CH; k++) begin
          s3 = 3'($urandom_range(0, 7));
          bus.div_sel[k*SEL_W +: SEL_W] = s3;
        end
      end
`ifdef CNT_CLK_DIV_GEN_GATE_EN
      if ($urandom_range(0, 29) == 0) ch_en_tb = 4'($urandom);
`endif
      step(1);
    end
    sys_rst = 1'b0; bus.sync_clr = 1'b0;
    step(2);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
